// File: rtl/nn_backprop_trainer_if.sv
// Handshake and parameter bus between the training engine and its user.
// The forward network reads the weight/bias fields directly.
interface nn_backprop_trainer_if;
  logic       start;
  logic [1:0] target, y, x1, x2;
  logic [1:0] f1, f2, f3, f4, f5;
  logic [1:0] w1, w2, w11, w12, w13, w21, w22, w23, w01, w02, w03;
  logic [3:0] b1, b2, b3, b4, b5, b6;
  logic       busy, done;

  modport master (
    output start, target, y, x1, x2, f1, f2, f3, f4, f5,
    input  w1, w2, w11, w12, w13, w21, w22, w23, w01, w02, w03,
    input  b1, b2, b3, b4, b5, b6, busy, done
  );

  modport slave (
    input  start, target, y, x1, x2, f1, f2, f3, f4, f5,
    output w1, w2, w11, w12, w13, w21, w22, w23, w01, w02, w03,
    output b1, b2, b3, b4, b5, b6, busy, done
  );
endinterface

// File: rtl/nn_backprop_trainer.sv
// Sequential backprop engine for the 2-3-1 network: owns the parameter file and
// applies one signed, saturating update per cycle, walking output layer to input layer.
module nn_backprop_trainer #(
  parameter int unsigned LR_SHIFT = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  nn_backprop_trainer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StUpdate, StFinish, StDone} state_e;

  // Weight slots: 0 w1, 1 w2, 2..4 w11..w13, 5..7 w21..w23, 8..10 w01..w03
  // Activation slots: 0 x1, 1 x2, 2..6 f1..f5
  state_e            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic signed [2:0] e_q, e_d;
  logic [1:0]        w_q [11];
  logic [1:0]        w_d [11];
  logic [1:0]        ws_q [11];
  logic [1:0]        ws_d [11];
  logic [3:0]        b_q [6];
  logic [3:0]        b_d [6];
  logic [1:0]        a_q [7];
  logic [1:0]        a_d [7];

  logic              is_w, is_b;
  logic [3:0]        wsel;
  logic [2:0]        bsel;
  logic signed [2:0] d, sgn;
  logic signed [2:0] dh [3];
  logic signed [2:0] di [2];
  logic [1:0]        a;
  logic signed [5:0] d_ext, a_ext, prod, shr, wsum, bsum;
  logic [1:0]        wnew;
  logic [3:0]        bnew;

  // Deltas come from the snapshot so earlier updates in this step never leak in.
  always_comb begin
    sgn = e_q[2] ? -3'sd1 : 3'sd1;
    for (int k = 0; k < 3; k++) begin
      dh[k] = (ws_q[8+k] == 2'd0) ? 3'sd0 : sgn;
    end
    di[0] = ((ws_q[2] | ws_q[3] | ws_q[4]) == 2'd0) ? 3'sd0 : sgn;
    di[1] = ((ws_q[5] | ws_q[6] | ws_q[7]) == 2'd0) ? 3'sd0 : sgn;
  end

  always_comb begin
    is_w = 1'b0;
    is_b = 1'b0;
    wsel = 4'd0;
    bsel = 3'd0;
    d    = 3'sd0;
    a    = 2'd0;
    case (idx_q)
      5'd0:  begin is_w = 1'b1; wsel = 4'd8;  d = e_q;   a = a_q[4]; end
      5'd1:  begin is_w = 1'b1; wsel = 4'd9;  d = e_q;   a = a_q[5]; end
      5'd2:  begin is_w = 1'b1; wsel = 4'd10; d = e_q;   a = a_q[6]; end
      5'd3:  begin is_b = 1'b1; bsel = 3'd5;  d = e_q;               end
      5'd4:  begin is_w = 1'b1; wsel = 4'd2;  d = dh[0]; a = a_q[2]; end
      5'd5:  begin is_w = 1'b1; wsel = 4'd5;  d = dh[0]; a = a_q[3]; end
      5'd6:  begin is_b = 1'b1; bsel = 3'd2;  d = dh[0];             end
      5'd7:  begin is_w = 1'b1; wsel = 4'd3;  d = dh[1]; a = a_q[2]; end
      5'd8:  begin is_w = 1'b1; wsel = 4'd6;  d = dh[1]; a = a_q[3]; end
      5'd9:  begin is_b = 1'b1; bsel = 3'd3;  d = dh[1];             end
      5'd10: begin is_w = 1'b1; wsel = 4'd4;  d = dh[2]; a = a_q[2]; end
      5'd11: begin is_w = 1'b1; wsel = 4'd7;  d = dh[2]; a = a_q[3]; end
      5'd12: begin is_b = 1'b1; bsel = 3'd4;  d = dh[2];             end
      5'd13: begin is_w = 1'b1; wsel = 4'd0;  d = di[0]; a = a_q[0]; end
      5'd14: begin is_b = 1'b1; bsel = 3'd0;  d = di[0];             end
      5'd15: begin is_w = 1'b1; wsel = 4'd1;  d = di[1]; a = a_q[1]; end
      5'd16: begin is_b = 1'b1; bsel = 3'd1;  d = di[1];             end
      default: ;
    endcase
  end

  always_comb begin
    d_ext = {{3{d[2]}}, d};
    a_ext = {4'b0000, a};
    prod  = d_ext * a_ext;
    shr   = prod >>> LR_SHIFT;
    wsum  = shr + $signed({4'b0000, w_q[wsel]});
    bsum  = $signed({2'b00, b_q[bsel]}) + d_ext;
    if (wsum < 6'sd0)      wnew = 2'd0;
    else if (wsum > 6'sd3) wnew = 2'd3;
    else                   wnew = wsum[1:0];
    if (bsum < 6'sd0)       bnew = 4'd0;
    else if (bsum > 6'sd15) bnew = 4'd15;
    else                    bnew = bsum[3:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    e_d     = e_q;
    ws_d    = ws_q;
    a_d     = a_q;
    w_d     = w_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (bus.start) begin
          e_d     = $signed({1'b0, bus.target}) - $signed({1'b0, bus.y});
          ws_d    = w_q;
          a_d     = '{bus.x1, bus.x2, bus.f1, bus.f2, bus.f3, bus.f4, bus.f5};
          busy_d  = 1'b1;
          idx_d   = 5'd0;
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        // Zero error skips straight to FINISH without touching any parameter.
        if (e_q == 3'sd0) begin
          state_d = StFinish;
        end else begin
          if (is_w) w_d[wsel] = wnew;
          if (is_b) b_d[bsel] = bnew;
          if (idx_q == 5'd16) state_d = StFinish;
          else                idx_d   = idx_q + 5'd1;
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      e_q     <= 3'sd0;
      ws_q    <= '{default: 2'd1};
      a_q     <= '{default: 2'd0};
      w_q     <= '{default: 2'd1};
      b_q     <= '{default: 4'd0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      e_q     <= e_d;
      ws_q    <= ws_d;
      a_q     <= a_d;
      w_q     <= w_d;
      b_q     <= b_d;
    end
  end

  assign bus.w1   = w_q[0];
  assign bus.w2   = w_q[1];
  assign bus.w11  = w_q[2];
  assign bus.w12  = w_q[3];
  assign bus.w13  = w_q[4];
  assign bus.w21  = w_q[5];
  assign bus.w22  = w_q[6];
  assign bus.w23  = w_q[7];
  assign bus.w01  = w_q[8];
  assign bus.w02  = w_q[9];
  assign bus.w03  = w_q[10];
  assign bus.b1   = b_q[0];
  assign bus.b2   = b_q[1];
  assign bus.b3   = b_q[2];
  assign bus.b4   = b_q[3];
  assign bus.b5   = b_q[4];
  assign bus.b6   = b_q[5];
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
